// File: rtl/run_link_pkg.sv
// Shared definitions for the run-detect serial link.
// Both the transmitter (run_burst_tx) and the receiving run detector import
// this package so they agree on field widths and the minimum gap.
package run_link_pkg;
  localparam int LEN_W_DEF   = 8;
  localparam int GAP_MIN_DEF = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } run_tx_state_t;
endpackage

// File: rtl/run_len_counter.sv
// Loadable down-counter used to time RUN and GAP phases.
// Ports:
//   clk, reset : clock, synchronous active-low reset (count clears to 0)
//   load/value : load 'value' this cycle (has priority over dec)
//   dec        : decrement; saturates at 0, never wraps
//   last       : count == 1, i.e. this is the final cycle of the phase
module run_len_counter #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LEN_W-1:0] value,
  input  logic             dec,
  output logic             last
);
  logic [LEN_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                  cnt_d = value;
    else if (dec && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign last = (cnt_q == LEN_W'(1));
endmodule

// File: rtl/run_burst_tx.sv
// Transmit end of the run-detect link. Each accepted {run_len, gap_len}
// command drives out_signal high for run_len cycles, then low for
// max(gap_len, GAP_MIN) cycles. A new command may be taken on the last gap
// cycle so bursts can be chained with no idle cycle in between.
// Ports:
//   clk, reset             : clock, synchronous active-low reset
//   cmd_valid/cmd_ready    : command handshake
//   cmd_run_len/gap_len    : command fields, sampled only on accept
//   out_signal             : registered serial line
//   busy                   : high in RUN or GAP
//   run_done               : pulse on the last gap cycle of each command
module run_burst_tx
  import run_link_pkg::*;
#(
  parameter int LEN_W   = LEN_W_DEF,
  parameter int GAP_MIN = GAP_MIN_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_run_len,
  input  logic [LEN_W-1:0] cmd_gap_len,
  output logic             out_signal,
  output logic             busy,
  output logic             run_done
);
  run_tx_state_t    state_q, state_d;
  logic [LEN_W-1:0] gap_q, gap_d;
  logic             out_q, out_d;
  logic             cnt_load, cnt_dec, cnt_last;
  logic [LEN_W-1:0] cnt_val;
  logic [LEN_W-1:0] eff_gap;
  logic             accept;

  localparam logic [LEN_W-1:0] GAP_MIN_V = LEN_W'(GAP_MIN);

  assign eff_gap = (cmd_gap_len < GAP_MIN_V) ? GAP_MIN_V : cmd_gap_len;

  run_len_counter #(.LEN_W(LEN_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .value (cnt_val),
    .dec   (cnt_dec),
    .last  (cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    // Ready in IDLE or on the final gap cycle; held low while in reset.
    cmd_ready = reset && ((state_q == IDLE) || (state_q == GAP && cnt_last));
    accept    = cmd_valid && cmd_ready;

    case (state_q)
      IDLE: ;
      RUN: begin
        if (cnt_last) begin
          state_d  = GAP;
          cnt_load = 1'b1;
          cnt_val  = gap_q;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      GAP: begin
        if (cnt_last) state_d = IDLE;
        else          cnt_dec = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // An accept overrides the phase logic above; a zero run goes straight to GAP.
    if (accept) begin
      gap_d    = eff_gap;
      cnt_load = 1'b1;
      if (cmd_run_len != '0) begin
        state_d = RUN;
        cnt_val = cmd_run_len;
      end else begin
        state_d = GAP;
        cnt_val = eff_gap;
      end
    end

    out_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      gap_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      out_q   <= out_d;
    end
  end

  assign out_signal = out_q;
  assign busy       = reset && (state_q != IDLE);
  assign run_done   = reset && (state_q == GAP) && cnt_last;
endmodule

// File: tb/tb_run_burst_tx.sv
module tb_run_burst_tx;
  localparam int LEN_W   = 8;
  localparam int GAP_MIN = 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_run_len;
  logic [LEN_W-1:0] cmd_gap_len;
  logic             out_signal;
  logic             busy;
  logic             run_done;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed { logic val; logic last; } exp_bit_t;
  exp_bit_t exp_q[$];
  bit prev_rst_low = 1'b0;

  always #5 clk = ~clk;

  run_burst_tx #(.LEN_W(LEN_W), .GAP_MIN(GAP_MIN)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_run_len (cmd_run_len),
    .cmd_gap_len (cmd_gap_len),
    .out_signal  (out_signal),
    .busy        (busy),
    .run_done    (run_done)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference: a command becomes a list of line bits, run ones then
  // max(gap, GAP_MIN) zeros, the final one tagged as the done cycle.
  task automatic model_push(input int r, input int g);
    int eg;
    eg = (g < GAP_MIN) ? GAP_MIN : g;
    for (int i = 0; i < r; i++) exp_q.push_back('{val: 1'b1, last: 1'b0});
    for (int i = 0; i < eg; i++) exp_q.push_back('{val: 1'b0, last: (i == eg - 1)});
  endtask

  // Monitor: once per cycle, away from the active edge.
  always @(negedge clk) begin
    exp_bit_t e;
    if (reset !== 1'b1) begin
      chk("rst_ready", int'(cmd_ready), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(run_done), 0);
      if (prev_rst_low) chk("rst_out", int'(out_signal), 0);
      exp_q.delete();
      prev_rst_low = 1'b1;
    end else begin
      prev_rst_low = 1'b0;
      chk("ready", int'(cmd_ready), int'(exp_q.size() <= 1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("busy", int'(busy), 1);
        chk("out", int'(out_signal), int'(e.val));
        chk("done", int'(run_done), int'(e.last));
      end else begin
        chk("idle_busy", int'(busy), 0);
        chk("idle_out", int'(out_signal), 0);
        chk("idle_done", int'(run_done), 0);
      end
      // Command taken at the coming edge: its bits start next cycle.
      if (cmd_valid && cmd_ready) model_push(int'(cmd_run_len), int'(cmd_gap_len));
    end
  end

  // Present a command and hold it until the coming edge accepts it.
  task automatic send(input int r, input int g);
    bit ok;
    ok = 1'b0;
    cmd_valid   = 1'b1;
    cmd_run_len = LEN_W'(r);
    cmd_gap_len = LEN_W'(g);
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    cmd_valid   = 1'b0;
    cmd_run_len = LEN_W'($urandom);
    cmd_gap_len = LEN_W'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((exp_q.size() > 0 || busy) && i < 1000) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("drain_timeout", int'(i < 1000), 1);
  endtask

  initial begin
    reset       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_run_len = '0;
    cmd_gap_len = '0;
    idle(3);
    reset = 1'b1;
    idle(2);

    send(3, 2);                 // basic burst
    drain(); idle(2);
    send(0, 0);                 // zero run, gap clamped to GAP_MIN
    drain(); idle(2);
    send(2, 1);                 // back-to-back, valid held across
    send(4, 1);
    drain(); idle(1);
    send(1, 3);                 // single-one run
    drain(); idle(1);

    send(5, 3);                 // reset in the 2nd run cycle
    idle(1);
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(2);
    send(2, 2);                 // clean restart
    drain();

    send(255, 0);               // full-scale run length
    drain();

    for (int k = 0; k < 60; k++) begin
      int r, g;
      r = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 9));
      g = int'($urandom_range(0, 4));
      send(r, g);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(0, 3)));
    end
    drain();
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
